// File: rtl/zap_sync_fifo_pkg.sv
// zap_sync_fifo_pkg: width helpers and skid occupancy type for zap_sync_fifo
package zap_sync_fifo_pkg;
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction
   typedef logic [1:0] skid_occ_t;
endpackage

// File: rtl/zap_ram_simple.sv
// zap_ram_simple: 1R+1W block RAM with one-cycle registered read
module zap_ram_simple
   import zap_sync_fifo_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32
) (
   input  logic                     i_clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_data
);
   logic [WIDTH-1:0] mem [DEPTH];
   // write port and registered read port
   always_ff @(posedge i_clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/zap_sync_fifo.sv
// zap_sync_fifo: FWFT FIFO over zap_ram_simple with 2-entry skid; ZAP_SYNC_FIFO_ERR_EN enables sticky error flags
module zap_sync_fifo
   import zap_sync_fifo_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_wr_en,
   input  logic [WIDTH-1:0]          i_wr_data,
   output logic                      o_full,
   input  logic                      i_rd_en,
   output logic [WIDTH-1:0]          o_rd_data,
   output logic                      o_empty,
   output logic [cnt_w(DEPTH)-1:0]   o_count,
   output logic                      o_overflow,
   output logic                      o_underflow
);
   localparam int PW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);
   localparam int AW = PW - 1;
   logic [PW-1:0] wp, rp;
   logic inflight;
   skid_occ_t occ;
   logic [WIDTH-1:0] skid0, skid1, ram_q;
   logic push, pop, rd_issue, bypass, pop_skid, load;
   logic [2:0] after_pop;
   assign o_empty = ~(inflight | (occ != 2'd0));
   assign o_full = o_count == CW'(DEPTH);
   assign o_rd_data = bypass ? ram_q : skid0;
   // request acceptance, head selection and RAM read issue
   always_comb begin
      push = i_wr_en & ~o_full;
      pop = i_rd_en & ~o_empty;
      bypass = (occ == 2'd0) & inflight;
      pop_skid = pop & ~bypass;
      load = inflight & ~(bypass & pop);
      after_pop = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
      rd_issue = (wp != rp) & (after_pop < 3'd2);
   end
   // pointers, in-flight marker, skid occupancy and entry count
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wp <= '0;
         rp <= '0;
         inflight <= 1'b0;
         occ <= '0;
         o_count <= '0;
      end else begin
         wp <= wp + PW'(push);
         rp <= rp + PW'(rd_issue);
         inflight <= rd_issue;
         occ <= occ - skid_occ_t'(pop_skid) + skid_occ_t'(load);
         o_count <= o_count + CW'(push) - CW'(pop);
      end
   end
   // skid data: shift on pop, append the returning RAM word behind what remains
   always_ff @(posedge i_clk) begin
      if (pop_skid) skid0 <= skid1;
      if (load) begin
         if (occ == skid_occ_t'(pop_skid)) skid0 <= ram_q;
         else skid1 <= ram_q;
      end
   end
`ifdef ZAP_SYNC_FIFO_ERR_EN
   // sticky illegal-request flags, cleared only by reset
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_overflow <= 1'b0;
         o_underflow <= 1'b0;
      end else begin
         o_overflow <= o_overflow | (i_wr_en & o_full);
         o_underflow <= o_underflow | (i_rd_en & o_empty);
      end
   end
`else
   assign o_overflow = 1'b0;
   assign o_underflow = 1'b0;
`endif
   zap_ram_simple #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
      .i_clk   (i_clk),
      .wr_en   (push),
      .wr_addr (wp[AW-1:0]),
      .wr_data (i_wr_data),
      .rd_en   (rd_issue),
      .rd_addr (rp[AW-1:0]),
      .rd_data (ram_q)
   );
endmodule

// File: tb/tb_zap_sync_fifo.sv
// tb_zap_sync_fifo: directed scoreboard bench for zap_sync_fifo
module tb_zap_sync_fifo;
   localparam int WIDTH = 32;
   localparam int DEPTH = 32;
`ifdef ZAP_SYNC_FIFO_ERR_EN
   localparam bit ERR = 1'b1;
`else
   localparam bit ERR = 1'b0;
`endif
   logic i_clk = 1'b0;
   logic i_reset = 1'b1;
   logic i_wr_en = 1'b0;
   logic i_rd_en = 1'b0;
   logic [WIDTH-1:0] i_wr_data = '0;
   logic o_full, o_empty, o_overflow, o_underflow;
   logic [WIDTH-1:0] o_rd_data;
   logic [5:0] o_count;
   int checks = 0;
   int fails = 0;
   int exp_cnt = 0;
   logic exp_ovf = 1'b0;
   logic exp_unf = 1'b0;
   logic [31:0] q[$];

   zap_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_wr_en     (i_wr_en),
      .i_wr_data   (i_wr_data),
      .o_full      (o_full),
      .i_rd_en     (i_rd_en),
      .o_rd_data   (o_rd_data),
      .o_empty     (o_empty),
      .o_count     (o_count),
      .o_overflow  (o_overflow),
      .o_underflow (o_underflow)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   // one cycle of stimulus; accepted pushes go to the scoreboard
   task automatic step(input logic we, input logic [31:0] wd, input logic re);
      logic pa, pp, ov, un;
      i_wr_en = we;
      i_wr_data = wd;
      i_rd_en = re;
      pa = we && exp_cnt != DEPTH;
      pp = re && !o_empty;
      ov = we && exp_cnt == DEPTH;
      un = re && o_empty;
      if (pa) q.push_back(wd);
      @(posedge i_clk);
      #1;
      exp_cnt = exp_cnt + int'(pa) - int'(pp);
      if (ov) exp_ovf = ERR;
      if (un) exp_unf = ERR;
      i_wr_en = 1'b0;
      i_rd_en = 1'b0;
   endtask

   task automatic do_reset(input logic we, input logic re);
      i_reset = 1'b1;
      i_wr_en = we;
      i_rd_en = re;
      i_wr_data = 32'h0BAD;
      @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      i_wr_en = 1'b0;
      i_rd_en = 1'b0;
      q.delete();
      exp_cnt = 0;
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
   endtask

   // monitor: status every cycle, head data on every accepted pop
   always @(negedge i_clk) begin
      if (!i_reset) begin
         chk("count", 32'(o_count), exp_cnt);
         chk("full", 32'(o_full), 32'(exp_cnt == DEPTH));
         chk("overflow", 32'(o_overflow), 32'(exp_ovf));
         chk("underflow", 32'(o_underflow), 32'(exp_unf));
         if (i_rd_en && !o_empty) begin
            if (q.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL head: got %h expected no entry", o_rd_data);
            end else chk("head", o_rd_data, q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int sent;
      logic we, re;
      do_reset(1'b0, 1'b0);
      chk("rst_empty", 32'(o_empty), 1);
      chk("rst_full", 32'(o_full), 0);
      chk("rst_count", 32'(o_count), 0);
      chk("rst_ovf", 32'(o_overflow), 0);
      chk("rst_unf", 32'(o_underflow), 0);
      // write-to-visible latency
      step(1'b1, 32'hA5A5_0001, 1'b0);
      chk("lat_n1_empty", 32'(o_empty), 1);
      step(1'b0, 0, 1'b0);
      chk("lat_n2_empty", 32'(o_empty), 0);
      chk("lat_n2_data", o_rd_data, 32'hA5A5_0001);
      chk("lat_n2_count", 32'(o_count), 1);
      step(1'b0, 0, 1'b1);
      chk("lat_pop_empty", 32'(o_empty), 1);
      // fill, overflow, drain
      for (int i = 0; i < 32; i++) step(1'b1, i, 1'b0);
      chk("fill_full", 32'(o_full), 1);
      step(1'b1, 32'hDEAD, 1'b0);
      chk("fill_count", 32'(o_count), 32);
      chk("fill_ovf", 32'(o_overflow), 32'(ERR));
      for (int i = 0; i < 32; i++) step(1'b0, 0, 1'b1);
      chk("drain_empty", 32'(o_empty), 1);
      chk("drain_sb", q.size(), 0);
      // underflow
      step(1'b0, 0, 1'b1);
      chk("unf_empty", 32'(o_empty), 1);
      chk("unf_count", 32'(o_count), 0);
      chk("unf_flag", 32'(o_underflow), 32'(ERR));
      do_reset(1'b0, 1'b0);
      // half full streaming
      for (int i = 0; i < 16; i++) step(1'b1, 100 + i, 1'b0);
      step(1'b0, 0, 1'b0);
      step(1'b0, 0, 1'b0);
      for (int i = 0; i < 100; i++) begin
         chk("tp_no_bubble", 32'(o_empty), 0);
         step(1'b1, 200 + i, 1'b1);
         chk("tp_count", 32'(o_count), 16);
      end
      for (int i = 0; i < 40 && exp_cnt > 0; i++) step(1'b0, 0, 1'b1);
      chk("tp_drained", q.size(), 0);
      // full with simultaneous push and pop
      for (int i = 0; i < 32; i++) step(1'b1, 300 + i, 1'b0);
      step(1'b0, 0, 1'b0);
      step(1'b0, 0, 1'b0);
      chk("fpp_full", 32'(o_full), 1);
      step(1'b1, 32'h77, 1'b1);
      chk("fpp_count", 32'(o_count), 31);
      for (int i = 0; i < 31; i++) step(1'b0, 0, 1'b1);
      chk("fpp_empty", 32'(o_empty), 1);
      chk("fpp_sb", q.size(), 0);
      // wrap with random gaps
      do_reset(1'b0, 1'b0);
      sent = 0;
      for (int c = 0; c < 3000 && !(sent == 96 && exp_cnt == 0); c++) begin
         we = (sent < 96) && ($urandom_range(0, 1) == 1);
         re = $urandom_range(0, 1) == 1;
         step(we, 1000 + sent, re);
         if (we && q.size() > 0 && q[q.size() - 1] == 32'(1000 + sent)) sent++;
      end
      chk("wrap_done", 32'(sent == 96 && exp_cnt == 0), 1);
      // reset mid-stream
      for (int i = 0; i < 10; i++) step(1'b1, 2000 + i, i % 2 == 1);
      do_reset(1'b1, 1'b1);
      chk("mid_rst_empty", 32'(o_empty), 1);
      chk("mid_rst_count", 32'(o_count), 0);
      step(1'b1, 32'h55, 1'b0);
      step(1'b0, 0, 1'b0);
      chk("post_rst_data", o_rd_data, 32'h55);
      step(1'b0, 0, 1'b1);
      chk("post_rst_empty", 32'(o_empty), 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
